// File: rtl/otter_branch_predictor.sv
// -----------------------------------------------------------------------------
// otter_branch_predictor
//   Dynamic branch predictor and branch target buffer for the pipelined OTTER
//   core. For the current fetch PC it gives a zero-latency taken/target
//   prediction, which is combinational on pc_f. Execute trains the table once
//   a branch or jump resolves. The same resolve logic tells Execute when it
//   must redirect.
//
//   Ports
//     CLK, RESET_N        clock and asynchronous active-low reset
//     pc_f, lookup_en     fetch PC; fetch-advancing qualifier (statistics only)
//     pred_taken_f        predicted taken for pc_f
//     pred_target_f       predicted next PC (BTB target or pc_f+4)
//     pred_idx_f          table index used; travels down the pipe
//     upd_*               resolved-instruction information from Execute
//     mispredict_e        Execute must redirect and flush
//     correct_pc_e        redirect PC
//     stat_lookups        saturating count of cycles with lookup_en high
//     stat_mispredicts    saturating count of cycles with mispredict_e high
//
//   HIST_BITS = 0 selects bimodal indexing. A value from 1 to IDX_BITS
//   selects gshare, where the index is XORed with a non-speculative global
//   history register.
// -----------------------------------------------------------------------------
module otter_branch_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int TAG_BITS  = 8,
  parameter int HIST_BITS = 0,
  parameter int STAT_BITS = 32,
  localparam int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [XLEN-1:0]      pc_f,
  input  logic                 lookup_en,
  output logic                 pred_taken_f,
  output logic [XLEN-1:0]      pred_target_f,
  output logic [IDX_BITS-1:0]  pred_idx_f,
  input  logic                 upd_valid,
  input  logic [XLEN-1:0]      upd_pc,
  input  logic [IDX_BITS-1:0]  upd_idx,
  input  logic                 upd_is_branch,
  input  logic                 upd_is_jump,
  input  logic                 upd_taken,
  input  logic [XLEN-1:0]      upd_target,
  input  logic                 upd_pred_taken,
  input  logic [XLEN-1:0]      upd_pred_target,
  output logic                 mispredict_e,
  output logic [XLEN-1:0]      correct_pc_e,
  output logic [STAT_BITS-1:0] stat_lookups,
  output logic [STAT_BITS-1:0] stat_mispredicts
);

  localparam int TAG_LSB = IDX_BITS + 2;

  // Table storage (register array, asynchronous read)
  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  jump_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [STAT_BITS-1:0] lookups_q, mispred_q;

  // ---------------------------------------------------------------- lookup
  logic [IDX_BITS-1:0] pc_idx;
  logic [IDX_BITS-1:0] look_idx;
  logic [TAG_BITS-1:0] look_tag;
  logic                look_hit;

  assign pc_idx   = pc_f[IDX_BITS+1:2];
  assign look_tag = pc_f[TAG_LSB+TAG_BITS-1:TAG_LSB];

  generate
    if (HIST_BITS > 0) begin : g_gshare
      logic [HIST_BITS-1:0] ghr_q;
      logic [HIST_BITS-1:0] ghr_d;

      // The history is non-speculative. Only resolved conditional branches
      // shift it. The cast keeps the low HIST_BITS, so HIST_BITS=1 works too.
      assign ghr_d    = HIST_BITS'({ghr_q, upd_taken});
      assign look_idx = pc_idx ^ IDX_BITS'(ghr_q);

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          ghr_q <= '0;
        end else if (upd_valid && upd_is_branch) begin
          ghr_q <= ghr_d;
        end
      end
    end else begin : g_bimodal
      assign look_idx = pc_idx;
    end
  endgenerate

  assign look_hit      = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign pred_taken_f  = look_hit && (jump_q[look_idx] || ctr_q[look_idx][1]);
  assign pred_target_f = pred_taken_f ? target_q[look_idx] : pc_f + XLEN'(4);
  assign pred_idx_f    = look_idx;

  // --------------------------------------------------------------- resolve
  assign mispredict_e = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
  assign correct_pc_e = upd_taken ? upd_target : upd_pc + XLEN'(4);

  // -------------------------------------------------------------- training
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;
  logic                wr_en_d;
  logic                wr_valid_d;
  logic                wr_jump_d;
  logic [TAG_BITS-1:0] wr_tag_d;
  logic [XLEN-1:0]     wr_target_d;
  logic [1:0]          wr_ctr_d;

  assign upd_tag = upd_pc[TAG_LSB+TAG_BITS-1:TAG_LSB];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    wr_en_d     = 1'b0;
    wr_valid_d  = valid_q[upd_idx];
    wr_jump_d   = jump_q[upd_idx];
    wr_tag_d    = tag_q[upd_idx];
    wr_target_d = target_q[upd_idx];
    wr_ctr_d    = ctr_q[upd_idx];
    if (upd_valid) begin
      if (upd_is_jump) begin
        wr_en_d     = 1'b1;
        wr_valid_d  = 1'b1;
        wr_jump_d   = 1'b1;
        wr_tag_d    = upd_tag;
        wr_target_d = upd_target;
        wr_ctr_d    = 2'b11;
      end else if (upd_is_branch) begin
        if (upd_hit) begin
          wr_en_d = 1'b1;
          if (upd_taken) begin
            wr_ctr_d    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
            wr_target_d = upd_target;
          end else begin
            wr_ctr_d    = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
          end
        end else if (upd_taken) begin
          // Allocate weakly-taken, evicting whatever aliased here.
          wr_en_d     = 1'b1;
          wr_valid_d  = 1'b1;
          wr_jump_d   = 1'b0;
          wr_tag_d    = upd_tag;
          wr_target_d = upd_target;
          wr_ctr_d    = 2'b10;
        end
      end else if (upd_hit) begin
        // A non-control instruction matched an entry, so the entry is stale.
        wr_en_d    = 1'b1;
        wr_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_q <= '0;
      jump_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (wr_en_d) begin
      valid_q[upd_idx]  <= wr_valid_d;
      jump_q[upd_idx]   <= wr_jump_d;
      tag_q[upd_idx]    <= wr_tag_d;
      target_q[upd_idx] <= wr_target_d;
      ctr_q[upd_idx]    <= wr_ctr_d;
    end
  end

  // ------------------------------------------------------------ statistics
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      if (lookup_en && (lookups_q != '1)) lookups_q <= lookups_q + 1'b1;
      if (mispredict_e && (mispred_q != '1)) mispred_q <= mispred_q + 1'b1;
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_mispredicts = mispred_q;

endmodule

// File: tb/tb_otter_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_otter_branch_predictor
//   Self-checking bench. dut0 is bimodal with 4-bit statistics. dut1 is
//   gshare with HIST_BITS=4 and 32-bit statistics. Both duts share all inputs.
//   A vector table drives dut0 one cycle per record. The expected outputs are
//   pushed to a scoreboard queue when the record is driven, and popped on the
//   falling edge. Hand-written sequences cover reset mid-update, statistics
//   saturation and gshare history.
// -----------------------------------------------------------------------------
module tb_otter_branch_predictor;

  logic        CLK;
  logic        RESET_N;
  logic [31:0] pc_f;
  logic        lookup_en;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [3:0]  upd_idx;
  logic        upd_is_branch, upd_is_jump, upd_taken, upd_pred_taken;
  logic [31:0] upd_target, upd_pred_target;

  logic        pred_taken_f, mispredict_e;
  logic [31:0] pred_target_f, correct_pc_e;
  logic [3:0]  pred_idx_f;
  logic [3:0]  stat_lookups, stat_mispredicts;

  logic        g_pred_taken_f, g_mispredict_e;
  logic [31:0] g_pred_target_f, g_correct_pc_e;
  logic [3:0]  g_pred_idx_f;
  logic [31:0] g_stat_lookups, g_stat_mispredicts;

  otter_branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_BITS(8),
                           .HIST_BITS(0), .STAT_BITS(4)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .pc_f(pc_f), .lookup_en(lookup_en),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .pred_idx_f(pred_idx_f), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_idx(upd_idx), .upd_is_branch(upd_is_branch), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict_e(mispredict_e), .correct_pc_e(correct_pc_e),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts));

  otter_branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_BITS(8),
                           .HIST_BITS(4), .STAT_BITS(32)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .pc_f(pc_f), .lookup_en(lookup_en),
    .pred_taken_f(g_pred_taken_f), .pred_target_f(g_pred_target_f),
    .pred_idx_f(g_pred_idx_f), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_idx(upd_idx), .upd_is_branch(upd_is_branch), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict_e(g_mispredict_e), .correct_pc_e(g_correct_pc_e),
    .stat_lookups(g_stat_lookups), .stat_mispredicts(g_stat_mispredicts));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        br, jp, tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic [3:0]  e_idx;
    logic        e_mis;
    logic [31:0] e_cpc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(input logic [31:0] pc, input logic uv,
                              input logic [31:0] upc, input logic br, jp, tk,
                              input logic [31:0] tgt, input logic ptk,
                              input logic [31:0] ptgt, input logic e_tk,
                              input logic [31:0] e_tgt, input logic [3:0] e_idx,
                              input logic e_mis, input logic [31:0] e_cpc);
    vec_t v;
    v.pc = pc; v.uv = uv; v.upc = upc; v.br = br; v.jp = jp; v.tk = tk;
    v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt; v.e_tk = e_tk; v.e_tgt = e_tgt;
    v.e_idx = e_idx; v.e_mis = e_mis; v.e_cpc = e_cpc;
    return v;
  endfunction

  // Idle cycle: lookup only. correct_pc_e is then 0+4.
  function automatic vec_t idle(input logic [31:0] pc, input logic e_tk,
                                input logic [31:0] e_tgt, input logic [3:0] e_idx);
    return mk(pc, 0, 0, 0, 0, 0, 0, 0, 0, e_tk, e_tgt, e_idx, 0, 32'h4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive_upd(input logic le, input logic uv, input logic [31:0] upc,
                           input logic [3:0] idx, input logic br, jp, tk,
                           input logic [31:0] tgt, input logic ptk,
                           input logic [31:0] ptgt);
    lookup_en = le; upd_valid = uv; upd_pc = upc; upd_idx = idx;
    upd_is_branch = br; upd_is_jump = jp; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vec_t v, e;
    RESET_N = 1'b0;
    pc_f = 32'h100;
    drive_upd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // pc, uv, upc, br, jp, tk, tgt, ptk, ptgt | e_tk, e_tgt, e_idx, e_mis, e_cpc
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0, 32'h104, 0, 1, 32'h80));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80,  1, 32'h80,  0, 0, 32'h80));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80,  1, 32'h80,  0, 0, 32'h80));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 0, 0, 32'h0,  1, 32'h80,  1, 32'h80,  0, 1, 32'h104));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 0, 0, 32'h0,  1, 32'h80,  1, 32'h80,  0, 1, 32'h104));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(32'h100, 1, 32'h100, 1, 0, 0, 32'h0, 0, 32'h104, 0, 32'h104, 0, 0, 32'h104));
    // A taken update after the underflow attempts lifts ctr from 00 only to 01.
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0, 32'h104, 0, 1, 32'h80));
    vecs.push_back(idle(32'h100, 0, 32'h104, 0));
    // Jump at 0x200 (shares index 0 with 0x100)
    vecs.push_back(mk(32'h200, 1, 32'h200, 0, 1, 1, 32'h400, 0, 32'h204, 0, 32'h204, 0, 1, 32'h400));
    vecs.push_back(mk(32'h200, 1, 32'h200, 0, 1, 1, 32'h400, 1, 32'h400, 1, 32'h400, 0, 0, 32'h400));
    // Aliasing 0x100 / 0x140
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 0, 1, 32'h80));
    vecs.push_back(mk(32'h100, 1, 32'h140, 1, 0, 1, 32'h300, 0, 32'h144, 1, 32'h80,  0, 1, 32'h300));
    vecs.push_back(idle(32'h100, 0, 32'h104, 0));
    vecs.push_back(mk(32'h140, 1, 32'h140, 0, 0, 0, 32'h0, 1, 32'h300, 1, 32'h300, 0, 1, 32'h144));
    vecs.push_back(idle(32'h140, 0, 32'h144, 0));
    // Wrong target with correct direction still mispredicts.
    vecs.push_back(mk(32'h300, 1, 32'h500, 1, 0, 1, 32'h600, 1, 32'h700, 0, 32'h304, 0, 1, 32'h600));
    vecs.push_back(idle(32'hFFFF_FFFC, 0, 32'h0, 4'hF));
    vecs.push_back(idle(32'h502, 1, 32'h600, 0));
    // A not-taken branch that misses writes nothing.
    vecs.push_back(mk(32'h500, 1, 32'h700, 1, 0, 0, 32'h0, 0, 32'h704, 1, 32'h600, 0, 0, 32'h704));
    vecs.push_back(idle(32'h500, 1, 32'h600, 0));

    #12 RESET_N = 1'b1;
    tick();
    chk("reset_lookups", {28'h0, stat_lookups}, 32'h0);
    chk("reset_mispredicts", {28'h0, stat_mispredicts}, 32'h0);

    // ---------------- table-driven run with scoreboard
    foreach (vecs[k]) begin
      v = vecs[k];
      pc_f = v.pc;
      drive_upd(1, v.uv, v.upc, v.upc[5:2], v.br, v.jp, v.tk, v.tgt, v.ptk, v.ptgt);
      exp_q.push_back(v);
      @(negedge CLK);
      e = exp_q.pop_front();
      $display("vec %0d pc=%h taken=%0d target=%h idx=%h mis=%0d cpc=%h",
               k, pc_f, pred_taken_f, pred_target_f, pred_idx_f, mispredict_e, correct_pc_e);
      chk($sformatf("v%0d_taken", k), {31'h0, pred_taken_f}, {31'h0, e.e_tk});
      chk($sformatf("v%0d_target", k), pred_target_f, e.e_tgt);
      chk($sformatf("v%0d_idx", k), {28'h0, pred_idx_f}, {28'h0, e.e_idx});
      chk($sformatf("v%0d_mis", k), {31'h0, mispredict_e}, {31'h0, e.e_mis});
      chk($sformatf("v%0d_cpc", k), correct_pc_e, e.e_cpc);
      tick();
    end
    // 23 lookups saturate the 4-bit counter; 9 mispredicts were reported.
    $display("stats dut0 lookups=%0d mis=%0d dut1 lookups=%0d mis=%0d",
             stat_lookups, stat_mispredicts, g_stat_lookups, g_stat_mispredicts);
    chk("tbl_lookups_sat", {28'h0, stat_lookups}, 32'hF);
    chk("tbl_mispredicts", {28'h0, stat_mispredicts}, 32'd9);
    chk("tbl_g_lookups", g_stat_lookups, 32'd23);
    chk("tbl_g_mispredicts", g_stat_mispredicts, 32'd9);

    // ---------------- asynchronous reset during an update
    pc_f = 32'h500;
    drive_upd(1, 1, 32'h500, 4'h0, 1, 0, 1, 32'h600, 0, 32'h504);
    #3 RESET_N = 1'b0;
    #1;
    $display("reset mid-update taken=%0d target=%h mis=%0d", pred_taken_f, pred_target_f, mispredict_e);
    chk("rst_taken", {31'h0, pred_taken_f}, 32'h0);
    chk("rst_target", pred_target_f, 32'h504);
    chk("rst_lookups", {28'h0, stat_lookups}, 32'h0);
    chk("rst_mispredicts", {28'h0, stat_mispredicts}, 32'h0);
    chk("rst_mis_comb", {31'h0, mispredict_e}, 32'h1);
    chk("rst_cpc_comb", correct_pc_e, 32'h600);
    @(negedge CLK);
    drive_upd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    #1 RESET_N = 1'b1;
    tick();
    chk("post_rst_taken", {31'h0, pred_taken_f}, 32'h0);

    // ---------------- statistics counting and saturation
    drive_upd(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive_upd(0, 1, 32'h900, 4'h0, 0, 0, 1, 32'h40, 0, 32'h0);
    tick();
    $display("stats step lookups=%0d mis=%0d", stat_lookups, stat_mispredicts);
    chk("cnt_lookups", {28'h0, stat_lookups}, 32'd1);
    chk("cnt_mispredicts", {28'h0, stat_mispredicts}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      drive_upd(1, 1, 32'h900, 4'h0, 0, 0, 1, 32'h40, 0, 32'h0);
      tick();
    end
    $display("stats sat lookups=%0d mis=%0d", stat_lookups, stat_mispredicts);
    chk("sat_lookups", {28'h0, stat_lookups}, 32'hF);
    chk("sat_mispredicts", {28'h0, stat_mispredicts}, 32'hF);
    chk("g_cnt_lookups", g_stat_lookups, 32'd21);
    chk("g_cnt_mispredicts", g_stat_mispredicts, 32'd21);

    // ---------------- gshare history (dut1)
    pc_f = 32'h100;
    drive_upd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("gs_idx_init", {28'h0, g_pred_idx_f}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      drive_upd(0, 1, 32'h10, 4'h4, 1, 0, 1, 32'h20, 1, 32'h20);
      tick();
      drive_upd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      $display("gshare taken #%0d idx=%h", i, g_pred_idx_f);
      chk($sformatf("gs_idx_t%0d", i), {28'h0, g_pred_idx_f}, (32'h1 << i) - 32'h1);
    end
    chk("bimodal_idx", {28'h0, pred_idx_f}, 32'h0);
    drive_upd(0, 1, 32'h10, 4'h4, 0, 1, 1, 32'h20, 1, 32'h20);
    tick();
    drive_upd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("gs_idx_jump", {28'h0, g_pred_idx_f}, 32'hF);
    drive_upd(0, 1, 32'h10, 4'h4, 1, 0, 0, 32'h0, 0, 32'h14);
    tick();
    drive_upd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("gs_idx_nt", {28'h0, g_pred_idx_f}, 32'hE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/otter_branch_predictor.md
Name: otter_branch_predictor

Overview:
- Parametrised dynamic branch predictor and branch target buffer (BTB) for the pipelined OTTER core.
- Sits beside the Fetch-stage PC register. Predicts taken/target for the current fetch PC in the same cycle.
- Is trained by the Execute stage once the branch or jump resolves.
- Replaces static predict-not-taken: Execute flushes only on a reported mispredict. Supports bimodal or gshare indexing.

Parameters:
- XLEN, 32, data/address width.
- ENTRIES, 16, BTB/counter table depth; power of 2, minimum 2. IDX_BITS = log2(ENTRIES).
- TAG_BITS, 8, PC tag bits stored per entry; tag = pc[IDX_BITS+TAG_BITS+1 : IDX_BITS+2].
- HIST_BITS, 0, global history length. 0 selects bimodal; 1..IDX_BITS selects gshare.
- STAT_BITS, 32, width of statistics counters.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- pc_f  in  XLEN  current fetch PC.
- lookup_en  in  1  fetch advancing this cycle (not stalled); qualifies the lookup statistic only.
- pred_taken_f  out  1  predict taken.
- pred_target_f  out  XLEN  predicted next PC (target if taken, else pc_f+4).
- pred_idx_f  out  IDX_BITS  table index used; carried down the pipe with the instruction.
- upd_valid  in  1  resolved instruction in Execute; must be low when Execute is stalled or flushed.
- upd_pc  in  XLEN  PC of resolved instruction.
- upd_idx  in  IDX_BITS  pred_idx_f captured at that instruction's fetch.
- upd_is_branch  in  1  conditional branch.
- upd_is_jump  in  1  JAL/JALR.
- upd_taken  in  1  actual outcome (1 for jumps).
- upd_target  in  XLEN  actual taken target.
- upd_pred_taken  in  1  prediction made at fetch.
- upd_pred_target  in  XLEN  prediction made at fetch.
- mispredict_e  out  1  Execute must redirect and flush Decode/Execute.
- correct_pc_e  out  XLEN  redirect PC.
- stat_lookups  out  STAT_BITS  count of cycles with lookup_en high.
- stat_mispredicts  out  STAT_BITS  count of cycles with mispredict_e high.

Behaviour:
- Entry fields: valid, tag, target[XLEN], ctr[1:0], is_jump. Storage is a register array read asynchronously.
- Index: bimodal uses pc_f[IDX_BITS+1:2]. Gshare uses that value XOR zero-extended GHR[HIST_BITS-1:0].
- Prediction is combinational, zero latency:
  - hit = valid & tag match.
  - pred_taken_f = hit & (is_jump | ctr[1]).
  - pred_target_f = pred_taken_f ? target : pc_f+4.
- Resolve logic is combinational on the upd_* inputs.
  - mispredict_e = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).
  - correct_pc_e = upd_taken ? upd_target : upd_pc+4.
- Training happens on the clock edge when upd_valid is high, writing at upd_idx:
  - Jump: write valid=1, tag, target, ctr=11, is_jump=1. This applies on both hit and miss.
  - Branch, tag hit: ctr saturating +1 if taken, else saturating -1; clamps at 11 and 00. Overwrite target if taken.
  - Branch, miss, taken: allocate the entry with ctr=10, is_jump=0, and the target. A victim with a different tag is overwritten.
  - Branch, miss, not taken: no write.
  - Neither branch nor jump: if tag hits, clear valid (alias cleanup). mispredict_e still follows the formula.
- GHR (HIST_BITS>0) is non-speculative. On upd_valid & upd_is_branch it becomes {GHR[HIST_BITS-2:0], upd_taken}. Jumps do not shift it.
- A lookup and an update to the same index in the same cycle: the lookup sees pre-edge contents; the write is visible next cycle.
- Statistics counters saturate at all-ones and do not wrap.
- Reset (asynchronous, any time including mid-update):
  - All valid=0, ctr=01, is_jump=0, GHR=0, statistics=0.
  - Outputs after reset: pred_taken_f=0, pred_target_f=pc_f+4.
  - mispredict_e and correct_pc_e remain functions of the inputs.
- pc+4 arithmetic is XLEN-bit and wraps modulo 2^XLEN.
- PC bits [1:0] are ignored for index and tag.

Test Plan:
- After reset, pc_f=0x100 -> pred_taken_f=0, pred_target_f=0x104. Update with branch at 0x100, taken, target 0x80, pred 0/0x104 -> mispredict_e=1, correct_pc_e=0x80. Next cycle pc_f=0x100 -> pred_taken_f=1, pred_target_f=0x80 (ctr=10).
- Counter saturation: train the same branch taken 3 times, then not-taken once -> still predicted taken (11→10). A second not-taken -> predicted not-taken (01). Four further not-taken updates leave ctr at 00 with no underflow.
- Jump at 0x200 to 0x400, miss -> mispredict_e=1. Re-fetch 0x200 -> pred_taken_f=1, pred_target_f=0x400. Update with upd_taken=1, target 0x400, pred 1/0x400 -> mispredict_e=0.
- Aliasing with ENTRIES=16: 0x100 and 0x140 share an index. Allocate 0x100, then a taken branch at 0x140 -> 0x100 misses afterwards. A non-branch update at 0x140 with a tag hit -> entry invalidated.
- Gshare with HIST_BITS=4: four taken branch updates -> GHR=1111. Lookup at 0x100 uses index 0x0 XOR 0xF = 0xF, so pred_idx_f=0xF. A jump update leaves GHR unchanged.
- Assert RESET_N low mid-cycle while upd_valid=1 -> table and statistics clear immediately. Holding lookup_en=1 with a mispredict every cycle, starting at STAT_BITS=4 → both statistics saturate at 0xF.
